// File: rtl/aes_inv_core.sv
// AES inverse cipher (FIPS-197) for 128/192/256-bit keys: the key is expanded once into an
// internal schedule, then the rounds are walked in reverse, one per clock.

module aes_sbox #(
  parameter bit INV = 1'b0
) (
  input  logic [7:0] i_x,
  output logic [7:0] o_y
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and conveniently maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a};
    return d[15-n -: 8];
  endfunction

  generate
    if (INV) begin : g_inv
      logic [7:0] w_t;
      assign w_t = rotl(i_x, 1) ^ rotl(i_x, 3) ^ rotl(i_x, 6) ^ 8'h05;
      assign o_y = gf_inv(w_t);
    end else begin : g_fwd
      logic [7:0] w_b;
      assign w_b = gf_inv(i_x);
      assign o_y = w_b ^ rotl(w_b, 1) ^ rotl(w_b, 2) ^ rotl(w_b, 3) ^ rotl(w_b, 4) ^ 8'h63;
    end
  endgenerate
endmodule

module aes_inv_core #(
  parameter int K = 128
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic           i_rekey,
  input  logic [K-1:0]   i_key,
  input  logic [127:0]   i_cyphertext,
  output logic           o_busy,
  output logic           o_done,
  output logic [127:0]   o_plaintext
);
  localparam int NK = K / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  generate
    if (K != 128 && K != 192 && K != 256) begin : g_bad_k
      $error("aes_inv_core: K must be 128, 192 or 256");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_DEC} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [5:0]   r_idx;
  logic [2:0]   r_kpos;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round;
  logic         r_key_valid;
  logic [127:0] r_st;
  logic [127:0] r_pt;
  logic         r_done;
  logic [31:0]  r_w [NW];

  logic         w_need_exp;
  logic         w_kexp_last;
  logic [31:0]  w_prev;
  logic [31:0]  w_back;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub_out;
  logic [31:0]  w_temp;
  logic [5:0]   w_rk_base;
  logic [127:0] w_rk;
  logic [127:0] w_isr;
  logic [127:0] w_isb;
  logic [127:0] w_ark;
  logic [127:0] w_imc;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul_k(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {mul_k(a0, 4'he) ^ mul_k(a1, 4'hb) ^ mul_k(a2, 4'hd) ^ mul_k(a3, 4'h9),
            mul_k(a0, 4'h9) ^ mul_k(a1, 4'he) ^ mul_k(a2, 4'hb) ^ mul_k(a3, 4'hd),
            mul_k(a0, 4'hd) ^ mul_k(a1, 4'h9) ^ mul_k(a2, 4'he) ^ mul_k(a3, 4'hb),
            mul_k(a0, 4'hb) ^ mul_k(a1, 4'hd) ^ mul_k(a2, 4'h9) ^ mul_k(a3, 4'he)};
  endfunction

  assign w_need_exp  = i_rekey || !r_key_valid;
  assign w_kexp_last = (r_idx == 6'(4 * NR + 3));

  // Key expansion: r_kpos tracks i mod Nk, r_rcon tracks Rcon[i/Nk]
  assign w_prev   = r_w[r_idx - 6'd1];
  assign w_back   = r_w[r_idx - 6'(NK)];
  assign w_sub_in = (r_kpos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  genvar gb;
  generate
    for (gb = 0; gb < 4; gb++) begin : g_subword
      aes_sbox #(.INV(1'b0)) u_sb (
        .i_x (w_sub_in[31-8*gb -: 8]),
        .o_y (w_sub_out[31-8*gb -: 8])
      );
    end
  endgenerate

  always_comb begin
    w_temp = w_prev;
    if (r_kpos == 3'd0) w_temp = w_sub_out ^ {r_rcon, 24'h000000};
    else if (NK == 8 && r_kpos == 3'd4) w_temp = w_sub_out;
  end

  assign w_rk_base = {r_round, 2'b00};
  assign w_rk = {r_w[w_rk_base], r_w[w_rk_base + 6'd1], r_w[w_rk_base + 6'd2], r_w[w_rk_base + 6'd3]};

  genvar gc, gr;
  generate
    for (gc = 0; gc < 4; gc++) begin : g_col
      for (gr = 0; gr < 4; gr++) begin : g_row
        assign w_isr[127-32*gc-8*gr -: 8] = r_st[127-32*((gc-gr+4)%4)-8*gr -: 8];
        aes_sbox #(.INV(1'b1)) u_isb (
          .i_x (w_isr[127-32*gc-8*gr -: 8]),
          .o_y (w_isb[127-32*gc-8*gr -: 8])
        );
      end
      assign w_imc[127-32*gc -: 32] = inv_mix_col(w_ark[127-32*gc -: 32]);
    end
  endgenerate

  assign w_ark = w_isb ^ w_rk;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = w_need_exp ? S_KEYEXP : S_DEC;
      end
      S_KEYEXP: begin
        o_busy = 1'b1;
        if (w_kexp_last) w_state_nxt = S_DEC;
      end
      S_DEC: begin
        o_busy = 1'b1;
        if (r_round == 4'd0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_idx       <= 6'd0;
      r_kpos      <= 3'd0;
      r_rcon      <= 8'h01;
      r_round     <= 4'd0;
      r_key_valid <= 1'b0;
      r_st        <= 128'd0;
      r_pt        <= 128'd0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_st    <= i_cyphertext;
            r_idx   <= 6'(NK);
            r_kpos  <= 3'd0;
            r_rcon  <= 8'h01;
            r_round <= 4'(NR);
          end
        end
        S_KEYEXP: begin
          r_idx  <= r_idx + 6'd1;
          r_kpos <= (r_kpos == 3'(NK - 1)) ? 3'd0 : r_kpos + 3'd1;
          if (r_kpos == 3'd0) r_rcon <= xtime(r_rcon);
          if (w_kexp_last) r_key_valid <= 1'b1;
        end
        S_DEC: begin
          if (r_round == 4'(NR))   r_st <= r_st ^ w_rk;
          else if (r_round != 4'd0) r_st <= w_imc;
          else begin
            r_pt   <= w_ark;
            r_done <= 1'b1;
          end
          r_round <= r_round - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // The schedule needs no reset: r_key_valid gates whether it is trusted
  always_ff @(posedge i_clk) begin
    if (r_state == S_IDLE && i_start && w_need_exp) begin
      for (int j = 0; j < NK; j++) r_w[j] <= i_key[K-1-32*j -: 32];
    end else if (r_state == S_KEYEXP) begin
      r_w[r_idx] <= w_back ^ w_temp;
    end
  end

  assign o_done      = r_done;
  assign o_plaintext = r_pt;
endmodule
